// File: rtl/alu_issue_ctrl_pkg.sv
// alu_pkg: ALU operation codes, RV opcode/funct7 constants and issue FSM states.
package alu_pkg;
    typedef enum logic [3:0] {
        NOP = 4'b0000,
        ADD = 4'b0001,
        SUB = 4'b0010,
        AND = 4'b0011,
        SLL = 4'b0100,
        SRL = 4'b0101,
        OR  = 4'b0111,
        MUL = 4'b1000,
        SLT = 4'b1001,
        SGT = 4'b1010,
        SEQ = 4'b1011
    } alu_op_t;

    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} issue_state_t;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;
endpackage

// File: rtl/alu_issue_ctrl_decoder.sv
// alu_op_decoder: combinational R/I-type instruction decode to ALU op, register fields and immediate.
module alu_op_decoder
    import alu_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic [31:0] i_instr,
    output logic [3:0]  o_op,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [4:0]  o_rd,
    output logic [11:0] o_imm,
    output logic        o_use_imm,
    output logic        o_illegal
);
    logic [6:0] w_opc;
    logic [6:0] w_f7;
    logic [2:0] w_f3;
    logic       w_bad_idx;
    alu_op_t    w_r;
    alu_op_t    w_i;
    alu_op_t    w_op;

    assign w_opc     = i_instr[6:0];
    assign w_f3      = i_instr[14:12];
    assign w_f7      = i_instr[31:25];
    assign o_rd      = i_instr[11:7];
    assign o_rs1     = i_instr[19:15];
    assign o_rs2     = i_instr[24:20];
    assign o_imm     = i_instr[31:20];
    assign o_use_imm = w_opc == OPC_I;

    always_comb begin
        case ({w_f7, w_f3})
            {F7_BASE, 3'b000}: w_r = ADD;
            {F7_ALT,  3'b000}: w_r = SUB;
            {F7_BASE, 3'b111}: w_r = AND;
            {F7_BASE, 3'b001}: w_r = SLL;
            {F7_BASE, 3'b101}: w_r = SRL;
            {F7_BASE, 3'b110}: w_r = OR;
            {F7_MUL,  3'b000}: w_r = MUL;
            {F7_BASE, 3'b010}: w_r = SLT;
            {F7_ALT,  3'b010}: w_r = SGT;
            {F7_ALT,  3'b011}: w_r = SEQ;
            default:           w_r = NOP;
        endcase
    end

    // Shift immediates reuse funct7 as imm[11:5], which must be zero.
    always_comb begin
        case (w_f3)
            3'b000:  w_i = ADD;
            3'b111:  w_i = AND;
            3'b110:  w_i = OR;
            3'b010:  w_i = SLT;
            3'b001:  w_i = w_f7 == F7_BASE ? SLL : NOP;
            3'b101:  w_i = w_f7 == F7_BASE ? SRL : NOP;
            default: w_i = NOP;
        endcase
    end

    assign w_bad_idx = int'(o_rs1) >= NREG || int'(o_rd) >= NREG || (!o_use_imm && int'(o_rs2) >= NREG);
    assign w_op      = w_opc == OPC_R ? w_r : w_opc == OPC_I ? w_i : NOP;
    assign o_illegal = w_op == NOP || w_bad_idx;
    assign o_op      = o_illegal ? NOP : w_op;
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one decoded instruction at a time to a registered ALU, writes back rd and returns a response.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int OPW  = 5,
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_instr_valid,
    output logic            o_instr_ready,
    input  logic [31:0]     i_instr,
    output logic [OPW-1:0]  o_alu_op1,
    output logic [OPW-1:0]  o_alu_op2,
    output logic [3:0]      o_alu_ctrl,
    input  logic [XLEN-1:0] i_alu_result,
    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic [4:0]      o_rsp_rd,
    output logic [XLEN-1:0] o_rsp_data,
    output logic            o_rsp_illegal
);
    issue_state_t    r_state;
    issue_state_t    w_next;
    logic            r_en;
    logic            w_accept;
    logic [3:0]      w_op;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic [11:0]     w_imm;
    logic            w_use_imm;
    logic            w_illegal;
    logic [XLEN-1:0] w_src1;
    logic [XLEN-1:0] w_src2;
    logic            w_unused;
    logic [XLEN-1:0] r_rf [NREG];
    logic [OPW-1:0]  r_op1;
    logic [OPW-1:0]  r_op2;
    logic [3:0]      r_ctrl;
    logic [4:0]      r_rd;
    logic            r_ill;
    logic [XLEN-1:0] r_data;

    alu_op_decoder #(.NREG(NREG)) u_dec (
        .i_instr   (i_instr),
        .o_op      (w_op),
        .o_rs1     (w_rs1),
        .o_rs2     (w_rs2),
        .o_rd      (w_rd),
        .o_imm     (w_imm),
        .o_use_imm (w_use_imm),
        .o_illegal (w_illegal)
    );

    assign w_src1   = r_rf[w_rs1];
    assign w_src2   = r_rf[w_rs2];
    assign w_accept = i_instr_valid && o_instr_ready;
    assign w_unused = &{1'b0, w_imm, w_src1, w_src2};

    // r_en keeps instr_ready low while reset is held and for the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_en    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_en    <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? EXEC : IDLE;
            EXEC:    w_next = CAPT;
            CAPT:    w_next = RESP;
            RESP:    w_next = i_rsp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_instr_ready = r_en && r_state == IDLE;
        o_rsp_valid   = r_state == RESP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op1  <= '0;
            r_op2  <= '0;
            r_ctrl <= '0;
            r_rd   <= '0;
            r_ill  <= 1'b0;
            r_data <= '0;
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
        end else begin
            if (w_accept) begin
                r_op1  <= w_src1[OPW-1:0];
                r_op2  <= w_use_imm ? w_imm[OPW-1:0] : w_src2[OPW-1:0];
                r_ctrl <= w_op;
                r_rd   <= w_rd;
                r_ill  <= w_illegal;
            end
            if (r_state == CAPT) begin
                r_data <= i_alu_result;
                if (!r_ill && r_rd != 5'd0) r_rf[r_rd] <= i_alu_result;
            end
        end
    end

    assign o_alu_op1     = r_op1;
    assign o_alu_op2     = r_op2;
    assign o_alu_ctrl    = r_ctrl;
    assign o_rsp_rd      = r_rd;
    assign o_rsp_data    = r_data;
    assign o_rsp_illegal = r_ill;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed vectors into a scoreboard queue, popped by a response monitor against a registered ALU model.
module tb_alu_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_instr_valid = 1'b0;
    logic        o_instr_ready;
    logic [31:0] i_instr = '0;
    logic [4:0]  o_alu_op1;
    logic [4:0]  o_alu_op2;
    logic [3:0]  o_alu_ctrl;
    logic [31:0] alu_result = '0;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [4:0]  o_rsp_rd;
    logic [31:0] o_rsp_data;
    logic        o_rsp_illegal;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        ill;
        logic [4:0]  op1;
        logic [4:0]  op2;
        logic [3:0]  ctrl;
        int          hold;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   hs_cyc = -1;
    int   rst_cyc = 0;

    alu_issue_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_instr_valid (i_instr_valid),
        .o_instr_ready (o_instr_ready),
        .i_instr       (i_instr),
        .o_alu_op1     (o_alu_op1),
        .o_alu_op2     (o_alu_op2),
        .o_alu_ctrl    (o_alu_ctrl),
        .i_alu_result  (alu_result),
        .o_rsp_valid   (o_rsp_valid),
        .i_rsp_ready   (i_rsp_ready),
        .o_rsp_rd      (o_rsp_rd),
        .o_rsp_data    (o_rsp_data),
        .o_rsp_illegal (o_rsp_illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] alu_f(logic [4:0] a, logic [4:0] b, logic [3:0] c);
        logic [31:0] x;
        logic [31:0] y;
        x = {27'b0, a};
        y = {27'b0, b};
        case (c)
            4'd1:    return x + y;
            4'd2:    return x - y;
            4'd3:    return x & y;
            4'd4:    return x << b;
            4'd5:    return x >> b;
            4'd7:    return x | y;
            4'd8:    return x * y;
            4'd9:    return {31'b0, $signed(a) < $signed(b)};
            4'd10:   return {31'b0, $signed(a) > $signed(b)};
            4'd11:   return {31'b0, a == b};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) alu_result <= alu_f(o_alu_op1, o_alu_op2, o_alu_ctrl);

    function automatic logic [31:0] rt(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] it(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic issue(logic [31:0] w, logic [4:0] rd, logic [31:0] data, logic ill,
                         logic [4:0] op1, logic [4:0] op2, logic [3:0] ctrl, int hold, bit push);
        int t = 0;
        int acc;
        @(negedge clk);
        while (!o_instr_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!o_instr_ready) begin
            chk("ready_timeout", {31'b0, o_instr_ready}, 32'd1);
            return;
        end
        acc = cyc;
        i_instr = w;
        i_instr_valid = 1'b1;
        @(posedge clk);
        #1;
        i_instr_valid = 1'b0;
        if (hs_cyc > rst_cyc) chk("accept_after_handshake", acc, hs_cyc + 1);
        if (push) q.push_back('{rd, data, ill, op1, op2, ctrl, hold, acc});
    endtask

    initial begin
        exp_t e;
        i_rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (o_rsp_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("latency", cyc - e.acc, 32'd3);
                    chk("rsp_rd", o_rsp_rd, e.rd);
                    chk("rsp_data", o_rsp_data, e.data);
                    chk("rsp_illegal", o_rsp_illegal, e.ill);
                    chk("alu_ctrl", o_alu_ctrl, e.ctrl);
                    if (!e.ill) begin
                        chk("alu_op1", o_alu_op1, e.op1);
                        chk("alu_op2", o_alu_op2, e.op2);
                    end
                    for (int k = 0; k < e.hold; k++) begin
                        @(negedge clk);
                        chk("hold_valid", o_rsp_valid, 32'd1);
                        chk("hold_rd", o_rsp_rd, e.rd);
                        chk("hold_data", o_rsp_data, e.data);
                        chk("hold_instr_ready", o_instr_ready, 32'd0);
                    end
                end
                i_rsp_ready = 1'b1;
                hs_cyc = cyc;
                @(posedge clk);
                #1;
                i_rsp_ready = 1'b0;
            end
        end
    end

    initial begin
        int t;
        #12;
        chk("reset_ctrl", {o_instr_ready, o_rsp_valid, o_rsp_illegal, o_rsp_rd, o_alu_ctrl, o_alu_op1, o_alu_op2}, 32'd0);
        chk("reset_data", o_rsp_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(it(12'h001, 5'd0, 3'b000, 5'd1), 5'd1, 32'h1, 1'b0, 5'h00, 5'h01, 4'h1, 0, 1'b1);
        issue(it(12'h012, 5'd0, 3'b000, 5'd2), 5'd2, 32'h12, 1'b0, 5'h00, 5'h12, 4'h1, 0, 1'b1);
        issue(rt(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 5'd3, 32'h13, 1'b0, 5'h01, 5'h12, 4'h1, 0, 1'b1);
        issue(rt(7'h20, 5'd2, 5'd1, 3'b000, 5'd4), 5'd4, 32'hFFFF_FFEF, 1'b0, 5'h01, 5'h12, 4'h2, 0, 1'b1);
        issue(it(12'h01F, 5'd0, 3'b000, 5'd5), 5'd5, 32'h1F, 1'b0, 5'h00, 5'h1F, 4'h1, 0, 1'b1);
        issue(rt(7'h01, 5'd5, 5'd5, 3'b000, 5'd6), 5'd6, 32'h3C1, 1'b0, 5'h1F, 5'h1F, 4'h8, 0, 1'b1);
        issue(rt(7'h00, 5'd0, 5'd6, 3'b000, 5'd7), 5'd7, 32'h1, 1'b0, 5'h01, 5'h00, 4'h1, 4, 1'b1);
        issue(32'h0000_01FF, 5'd3, 32'h0, 1'b1, 5'h00, 5'h00, 4'h0, 0, 1'b1);
        issue(rt(7'h00, 5'd0, 5'd3, 3'b000, 5'd9), 5'd9, 32'h13, 1'b0, 5'h13, 5'h00, 4'h1, 0, 1'b1);
        issue(rt(7'h00, 5'd2, 5'd1, 3'b000, 5'd0), 5'd0, 32'h13, 1'b0, 5'h01, 5'h12, 4'h1, 0, 1'b1);
        issue(rt(7'h00, 5'd0, 5'd0, 3'b000, 5'd10), 5'd10, 32'h0, 1'b0, 5'h00, 5'h00, 4'h1, 0, 1'b1);
        issue(it(12'h003, 5'd1, 3'b001, 5'd11), 5'd11, 32'h8, 1'b0, 5'h01, 5'h03, 4'h4, 0, 1'b1);
        issue(it(12'h403, 5'd1, 3'b001, 5'd14), 5'd14, 32'h0, 1'b1, 5'h00, 5'h00, 4'h0, 0, 1'b1);
        issue(rt(7'h00, 5'd2, 5'd1, 3'b110, 5'd12), 5'd12, 32'h13, 1'b0, 5'h01, 5'h12, 4'h7, 0, 1'b1);
        issue(rt(7'h20, 5'd1, 5'd1, 3'b011, 5'd13), 5'd13, 32'h1, 1'b0, 5'h01, 5'h01, 4'hB, 0, 1'b1);
        issue(rt(7'h00, 5'd1, 5'd2, 3'b101, 5'd14), 5'd14, 32'h9, 1'b0, 5'h12, 5'h01, 4'h5, 0, 1'b1);

        issue(rt(7'h00, 5'd2, 5'd1, 3'b000, 5'd8), 5'd8, 32'h0, 1'b0, 5'h00, 5'h00, 4'h0, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        rst_cyc = cyc;
        chk("abort_ctrl", {o_instr_ready, o_rsp_valid, o_rsp_illegal, o_rsp_rd, o_alu_ctrl, o_alu_op1, o_alu_op2}, 32'd0);
        chk("abort_data", o_rsp_data, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int k = 1; k < 32; k++)
            issue(rt(7'h00, 5'd0, 5'(k), 3'b000, 5'(k)), 5'(k), 32'h0, 1'b0, 5'h00, 5'h00, 4'h1, 0, 1'b1);
        issue(it(12'h005, 5'd0, 3'b000, 5'd1), 5'd1, 32'h5, 1'b0, 5'h00, 5'h05, 4'h1, 0, 1'b1);
        issue(rt(7'h00, 5'd1, 5'd1, 3'b000, 5'd2), 5'd2, 32'hA, 1'b0, 5'h05, 5'h05, 4'h1, 0, 1'b1);

        t = 0;
        while (q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 32'd0);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
